// File: rtl/replica_sched.sv
// Shares one weight memory among NUM_REPLICA annealing replicas with round-robin
// read arbitration, and tracks the global minimum-energy result of a run.
module replica_sched #(
  parameter int NUM_REPLICA = 4,
  parameter int NUM_SPIN    = 256,
  parameter int PARALLELISM = 4,
  parameter int ENERGY_BIT  = 32,
  parameter int ITER_BIT    = 16,
  parameter int ADDR_BIT    = $clog2(NUM_SPIN / PARALLELISM),
  parameter int REP_BIT     = $clog2(NUM_REPLICA)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            start_i,
  input  logic                            flush_i,
  input  logic [ITER_BIT-1:0]             cfg_iter_num_i,
  input  logic [NUM_REPLICA-1:0]          rep_ren_i,
  input  logic [NUM_REPLICA*ADDR_BIT-1:0] rep_raddr_i,
  output logic [NUM_REPLICA-1:0]          rep_gnt_o,
  output logic [NUM_REPLICA-1:0]          rep_rvalid_o,
  output logic                            mem_ren_o,
  output logic [ADDR_BIT-1:0]             mem_raddr_o,
  input  logic [NUM_REPLICA-1:0]          energy_valid_i,
  input  logic [NUM_REPLICA*ENERGY_BIT-1:0] energy_i,
  input  logic [NUM_REPLICA*NUM_SPIN-1:0] spin_i,
  output logic [NUM_REPLICA-1:0]          energy_ready_o,
  output logic [ENERGY_BIT-1:0]           best_energy_o,
  output logic [NUM_SPIN-1:0]             best_spin_o,
  output logic [REP_BIT-1:0]              best_replica_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [1:0]                      state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ENERGY_BIT-1:0] ENERGY_MAX = {1'b0, {(ENERGY_BIT-1){1'b1}}};
  localparam logic [ITER_BIT-1:0]   ITER_MAX   = {ITER_BIT{1'b1}};

  logic [1:0]             state_q, state_d;
  logic [REP_BIT-1:0]     ptr_q, ptr_d;
  logic [NUM_REPLICA-1:0] pend_q, pend_d;
  logic [ITER_BIT-1:0]    iter_cnt_q [NUM_REPLICA];
  logic [ITER_BIT-1:0]    iter_cnt_d [NUM_REPLICA];
  logic [ENERGY_BIT-1:0]  best_energy_q, best_energy_d;
  logic [NUM_SPIN-1:0]    best_spin_q, best_spin_d;
  logic [REP_BIT-1:0]     best_replica_q, best_replica_d;

  logic                   flush_act;
  logic                   gnt_found;
  logic [REP_BIT-1:0]     gnt_idx;
  logic [REP_BIT-1:0]     cand;
  logic                   all_done;
  logic                   run_entry;
  logic [NUM_REPLICA-1:0] hs;
  logic                   sel_found;
  logic [REP_BIT-1:0]     sel_idx;
  logic [ENERGY_BIT-1:0]  sel_energy;

  assign flush_act = en_i & flush_i;

  // Round-robin search starting at ptr_q; a flushing cycle issues no new read.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (en_i && !flush_i && state_q == S_RUN) begin
      for (int i = 0; i < NUM_REPLICA; i++) begin
        cand = REP_BIT'((int'(ptr_q) + i) % NUM_REPLICA);
        if (!gnt_found && rep_ren_i[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    rep_gnt_o   = '0;
    mem_raddr_o = '0;
    ptr_d       = ptr_q;
    if (gnt_found) begin
      rep_gnt_o[gnt_idx] = 1'b1;
      mem_raddr_o        = rep_raddr_i[int'(gnt_idx)*ADDR_BIT +: ADDR_BIT];
      ptr_d              = (gnt_idx == REP_BIT'(NUM_REPLICA - 1)) ? '0
                                                                  : gnt_idx + REP_BIT'(1);
    end
  end

  assign mem_ren_o = |rep_gnt_o;

  // Memory data arrives one cycle after the grant; a flush in that cycle hides it.
  assign pend_d       = rep_gnt_o;
  assign rep_rvalid_o = pend_q & ~{NUM_REPLICA{flush_act}};

  // Result handshake: a result from replica k is taken in a cycle where
  // energy_valid_i[k] and energy_ready_o[k] are both high; valid may wait on ready.
  always_comb begin
    all_done = 1'b1;
    for (int k = 0; k < NUM_REPLICA; k++) begin
      energy_ready_o[k] = en_i && (state_q == S_RUN) && (iter_cnt_q[k] < cfg_iter_num_i);
      if (iter_cnt_q[k] < cfg_iter_num_i) all_done = 1'b0;
    end
  end

  assign hs = energy_valid_i & energy_ready_o;

  // Signed minimum over this cycle's handshakes; strict compare keeps lowest index on ties.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_energy = '0;
    for (int k = 0; k < NUM_REPLICA; k++) begin
      if (hs[k] && (!sel_found ||
          $signed(energy_i[k*ENERGY_BIT +: ENERGY_BIT]) < $signed(sel_energy))) begin
        sel_found  = 1'b1;
        sel_idx    = REP_BIT'(k);
        sel_energy = energy_i[k*ENERGY_BIT +: ENERGY_BIT];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    run_entry = 1'b0;
    if (en_i) begin
      if (flush_i) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              state_d   = S_RUN;
              run_entry = 1'b1;
            end
          end
          S_RUN:   if (all_done) state_d = S_DRAIN;
          S_DRAIN: if (pend_q == '0) state_d = S_DONE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    best_energy_d  = best_energy_q;
    best_spin_d    = best_spin_q;
    best_replica_d = best_replica_q;
    for (int k = 0; k < NUM_REPLICA; k++) begin
      iter_cnt_d[k] = iter_cnt_q[k];
      if (run_entry) begin
        iter_cnt_d[k] = '0;
      end else if (hs[k] && iter_cnt_q[k] != ITER_MAX) begin
        iter_cnt_d[k] = iter_cnt_q[k] + ITER_BIT'(1);
      end
    end
    if (run_entry) begin
      best_energy_d  = ENERGY_MAX;
      best_spin_d    = '0;
      best_replica_d = '0;
    end else if (sel_found && $signed(sel_energy) < $signed(best_energy_q)) begin
      best_energy_d  = sel_energy;
      best_spin_d    = spin_i[int'(sel_idx)*NUM_SPIN +: NUM_SPIN];
      best_replica_d = sel_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      pend_q         <= '0;
      best_energy_q  <= ENERGY_MAX;
      best_spin_q    <= '0;
      best_replica_q <= '0;
      for (int k = 0; k < NUM_REPLICA; k++) iter_cnt_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      pend_q         <= pend_d;
      best_energy_q  <= best_energy_d;
      best_spin_q    <= best_spin_d;
      best_replica_q <= best_replica_d;
      for (int k = 0; k < NUM_REPLICA; k++) iter_cnt_q[k] <= iter_cnt_d[k];
    end
  end

  assign best_energy_o  = best_energy_q;
  assign best_spin_o    = best_spin_q;
  assign best_replica_o = best_replica_q;
  assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o         = (state_q == S_DONE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_replica_sched.sv
// Directed bench for replica_sched: arbitration vector table plus hand-written
// sequences for best-record tracking, iteration limits, flush, freeze and reset.
module tb_replica_sched;

  localparam int N    = 4;
  localparam int SPIN = 256;
  localparam int EB   = 32;
  localparam int IB   = 16;
  localparam int AB   = 6;
  localparam int RB   = 2;

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [1:0]  S_DONE  = 2'd3;
  localparam logic [31:0] E_MAX   = 32'h7FFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            start;
  logic            flush;
  logic [IB-1:0]   cfg_iter;
  logic [N-1:0]    ren;
  logic [N*AB-1:0] raddr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic            mem_ren;
  logic [AB-1:0]   mem_raddr;
  logic [N-1:0]    e_valid;
  logic [N*EB-1:0] energy;
  logic [N*SPIN-1:0] spin;
  logic [N-1:0]    e_ready;
  logic [EB-1:0]   best_energy;
  logic [SPIN-1:0] best_spin;
  logic [RB-1:0]   best_rep;
  logic            busy;
  logic            done;
  logic [1:0]      state;

  int n_cmp  = 0;
  int n_fail = 0;

  replica_sched dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start), .flush_i(flush),
    .cfg_iter_num_i(cfg_iter), .rep_ren_i(ren), .rep_raddr_i(raddr),
    .rep_gnt_o(gnt), .rep_rvalid_o(rvalid), .mem_ren_o(mem_ren),
    .mem_raddr_o(mem_raddr), .energy_valid_i(e_valid), .energy_i(energy),
    .spin_i(spin), .energy_ready_o(e_ready), .best_energy_o(best_energy),
    .best_spin_o(best_spin), .best_replica_o(best_rep), .busy_o(busy),
    .done_o(done), .state_o(state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [N-1:0]  ren;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic          mem_ren;
    logic [AB-1:0] raddr;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SPIN-1:0] spin_pat(input int k);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic set_e(input int k, input logic [EB-1:0] e);
    energy[k*EB +: EB] = e;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 4'b0001, 4'b0000, 1'b1, 6'd10};
    vecs[1]  = '{4'hF, 4'b0010, 4'b0001, 1'b1, 6'd11};
    vecs[2]  = '{4'hF, 4'b0100, 4'b0010, 1'b1, 6'd12};
    vecs[3]  = '{4'hF, 4'b1000, 4'b0100, 1'b1, 6'd13};
    vecs[4]  = '{4'hF, 4'b0001, 4'b1000, 1'b1, 6'd10};
    vecs[5]  = '{4'h0, 4'b0000, 4'b0001, 1'b0, 6'd0};
    vecs[6]  = '{4'h5, 4'b0100, 4'b0000, 1'b1, 6'd12};
    vecs[7]  = '{4'h5, 4'b0001, 4'b0100, 1'b1, 6'd10};
    vecs[8]  = '{4'h8, 4'b1000, 4'b0001, 1'b1, 6'd13};
    vecs[9]  = '{4'h6, 4'b0010, 4'b1000, 1'b1, 6'd11};
    vecs[10] = '{4'h0, 4'b0000, 4'b0010, 1'b0, 6'd0};

    // Reset
    rst = 1'b1; en = 1'b0; start = 1'b0; flush = 1'b0; cfg_iter = '0;
    ren = '0; e_valid = '0; energy = '0;
    raddr = {6'd13, 6'd12, 6'd11, 6'd10};
    for (int k = 0; k < N; k++) spin[k*SPIN +: SPIN] = spin_pat(k);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 256'(state), 256'(S_IDLE));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_best_e", 256'(best_energy), 256'(E_MAX));
    chk("rst_best_spin", 256'(best_spin), 256'(0));
    chk("rst_best_rep", 256'(best_rep), 256'(0));
    chk("rst_ready", 256'(e_ready), 256'(0));
    rst = 1'b0;
    cyc();

    // Arbitration table
    en = 1'b1; cfg_iter = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_state", 256'(state), 256'(S_RUN));
    chk("run_busy", 256'(busy), 256'(1));
    for (int i = 0; i < 11; i++) begin
      ren = vecs[i].ren;
      #1;
      chk($sformatf("vec%0d_gnt", i), 256'(gnt), 256'(vecs[i].gnt));
      chk($sformatf("vec%0d_rvalid", i), 256'(rvalid), 256'(vecs[i].rvalid));
      chk($sformatf("vec%0d_mem_ren", i), 256'(mem_ren), 256'(vecs[i].mem_ren));
      chk($sformatf("vec%0d_raddr", i), 256'(mem_raddr), 256'(vecs[i].raddr));
      chk($sformatf("vec%0d_ready", i), 256'(e_ready), 256'(4'hF));
      cyc();
    end
    ren = '0;

    // Tied minimum from replicas 1 and 3, later equal value from 2, then a new minimum
    e_valid = 4'b1010; set_e(1, -32'sd5); set_e(3, -32'sd5);
    cyc();
    e_valid = '0;
    chk("tie_best_e", 256'(best_energy), 256'(32'hFFFF_FFFB));
    chk("tie_best_rep", 256'(best_rep), 256'(1));
    chk("tie_best_spin", 256'(best_spin), 256'(spin_pat(1)));
    e_valid = 4'b0100; set_e(2, -32'sd5);
    cyc();
    e_valid = '0;
    chk("eq_best_e", 256'(best_energy), 256'(32'hFFFF_FFFB));
    chk("eq_best_rep", 256'(best_rep), 256'(1));
    e_valid = 4'b0001; set_e(0, -32'sd7);
    cyc();
    e_valid = '0;
    chk("new_best_e", 256'(best_energy), 256'(32'hFFFF_FFF9));
    chk("new_best_rep", 256'(best_rep), 256'(0));
    chk("new_best_spin", 256'(best_spin), 256'(spin_pat(0)));

    // Flush one cycle after a grant
    ren = 4'b0001;
    #1;
    chk("fl_gnt", 256'(gnt), 256'(4'b0001));
    cyc();
    ren = '0; flush = 1'b1;
    #1;
    chk("fl_rvalid", 256'(rvalid), 256'(0));
    chk("fl_gnt0", 256'(gnt), 256'(0));
    cyc();
    flush = 1'b0;
    chk("fl_state", 256'(state), 256'(S_IDLE));
    chk("fl_busy", 256'(busy), 256'(0));
    chk("fl_rvalid2", 256'(rvalid), 256'(0));

    // Iteration limit of 2 per replica
    cfg_iter = 16'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("it_state", 256'(state), 256'(S_RUN));
    chk("it_best_e", 256'(best_energy), 256'(E_MAX));
    chk("it_best_spin", 256'(best_spin), 256'(0));
    chk("it_best_rep", 256'(best_rep), 256'(0));
    e_valid = 4'hF;
    set_e(0, 32'sd3); set_e(1, 32'sd8); set_e(2, -32'sd2); set_e(3, 32'sd4);
    cyc();
    e_valid = '0;
    chk("it_a_best_e", 256'(best_energy), 256'(32'hFFFF_FFFE));
    chk("it_a_best_rep", 256'(best_rep), 256'(2));
    chk("it_a_best_spin", 256'(best_spin), 256'(spin_pat(2)));
    chk("it_a_ready", 256'(e_ready), 256'(4'hF));
    e_valid = 4'b0011; set_e(0, -32'sd2); set_e(1, 32'sd1);
    cyc();
    e_valid = '0;
    chk("it_b_best_rep", 256'(best_rep), 256'(2));
    chk("it_b_ready", 256'(e_ready), 256'(4'b1100));
    e_valid = 4'hF;
    set_e(0, -32'sd100); set_e(1, -32'sd100); set_e(2, -32'sd3); set_e(3, -32'sd3);
    #1;
    chk("it_c_ready", 256'(e_ready), 256'(4'b1100));
    cyc();
    e_valid = '0;
    chk("it_c_best_e", 256'(best_energy), 256'(32'hFFFF_FFFD));
    chk("it_c_best_rep", 256'(best_rep), 256'(2));
    chk("it_c_ready0", 256'(e_ready), 256'(0));
    chk("it_c_state", 256'(state), 256'(S_RUN));
    cyc();
    chk("it_drain", 256'(state), 256'(S_DRAIN));
    chk("it_drain_busy", 256'(busy), 256'(1));
    cyc();
    chk("it_done_state", 256'(state), 256'(S_DONE));
    chk("it_done", 256'(done), 256'(1));
    chk("it_done_busy", 256'(busy), 256'(0));

    // Zero iterations: RUN, DRAIN, DONE
    cfg_iter = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("z_run", 256'(state), 256'(S_RUN));
    chk("z_ready", 256'(e_ready), 256'(0));
    cyc();
    ren = 4'hF;
    #1;
    chk("z_drain", 256'(state), 256'(S_DRAIN));
    chk("z_drain_gnt", 256'(gnt), 256'(0));
    chk("z_drain_mem", 256'(mem_ren), 256'(0));
    cyc();
    chk("z_done", 256'(done), 256'(1));
    chk("z_done_gnt", 256'(gnt), 256'(0));
    chk("z_best_e", 256'(best_energy), 256'(E_MAX));
    ren = '0;

    // Freeze with en low, then asynchronous reset mid-run
    cfg_iter = 16'd3; start = 1'b1;
    cyc();
    start = 1'b0; ren = 4'hF;
    #1;
    chk("fz_gnt1", 256'(gnt), 256'(4'b0010));
    cyc();
    e_valid = 4'b0001; set_e(0, -32'sd1);
    #1;
    chk("fz_gnt2", 256'(gnt), 256'(4'b0100));
    cyc();
    e_valid = '0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fz%0d_state", i), 256'(state), 256'(S_RUN));
      chk($sformatf("fz%0d_gnt", i), 256'(gnt), 256'(0));
      chk($sformatf("fz%0d_ready", i), 256'(e_ready), 256'(0));
      chk($sformatf("fz%0d_mem", i), 256'(mem_ren), 256'(0));
      chk($sformatf("fz%0d_best", i), 256'(best_energy), 256'(32'hFFFF_FFFF));
      cyc();
    end
    en = 1'b1;
    #1;
    chk("fz_resume_gnt", 256'(gnt), 256'(4'b1000));
    chk("fz_resume_addr", 256'(mem_raddr), 256'(6'd13));
    rst = 1'b1;
    #1;
    chk("ar_state", 256'(state), 256'(S_IDLE));
    chk("ar_busy", 256'(busy), 256'(0));
    chk("ar_gnt", 256'(gnt), 256'(0));
    chk("ar_rvalid", 256'(rvalid), 256'(0));
    chk("ar_ready", 256'(e_ready), 256'(0));
    chk("ar_best_e", 256'(best_energy), 256'(E_MAX));
    chk("ar_best_rep", 256'(best_rep), 256'(0));
    cyc();
    rst = 1'b0; ren = '0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/replica_sched.md
REPLICA_SCHED -- requirements
Module: replica_sched

Interface
REQ-001 SHALL have parameter NUM_REPLICA, default 4: number of annealing replicas (each one digital macro) that share one weight memory, minimum 2.
REQ-002 SHALL have parameter NUM_SPIN, default 256: spins per replica.
REQ-003 SHALL have parameter PARALLELISM, default 4: spins covered by one weight row.
REQ-004 SHALL have parameter ENERGY_BIT, default 32: signed energy width.
REQ-005 SHALL have parameter ITER_BIT, default 16: iteration counter width.
REQ-006 SHALL have derived parameters ADDR_BIT = $clog2(NUM_SPIN/PARALLELISM) and REP_BIT = $clog2(NUM_REPLICA).
REQ-007 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-009 SHALL have port en_i  in  1  global enable; low freezes all state.
REQ-010 SHALL have port start_i  in  1  begin a run (sampled in IDLE or DONE).
REQ-011 SHALL have port flush_i  in  1  abort to IDLE.
REQ-012 SHALL have port cfg_iter_num_i  in  ITER_BIT  iterations required per replica.
REQ-013 SHALL have port rep_ren_i  in  NUM_REPLICA  per-replica weight read request.
REQ-014 SHALL have port rep_raddr_i  in  NUM_REPLICA*ADDR_BIT  per-replica read address; replica k at slice [k*ADDR_BIT +: ADDR_BIT].
REQ-015 SHALL have port rep_gnt_o  out  NUM_REPLICA  one-hot grant.
REQ-016 SHALL have port rep_rvalid_o  out  NUM_REPLICA  one-hot read data valid.
REQ-017 SHALL have port mem_ren_o  out  1  and mem_raddr_o  out  ADDR_BIT  to the shared weight memory (1-cycle read latency).
REQ-018 SHALL have port energy_valid_i  in  NUM_REPLICA; energy_i  in  NUM_REPLICA*ENERGY_BIT; spin_i  in  NUM_REPLICA*NUM_SPIN: per-replica result and its spin state.
REQ-019 SHALL have port energy_ready_o  out  NUM_REPLICA  per-replica result accept.
REQ-020 SHALL have port best_energy_o  out  ENERGY_BIT; best_spin_o  out  NUM_SPIN; best_replica_o  out  REP_BIT: global minimum record.
REQ-021 SHALL have port busy_o  out  1  (state RUN or DRAIN) and done_o  out  1  (state DONE).

Function
REQ-022 SHALL implement FSM states IDLE, RUN, DRAIN, DONE: IDLE/DONE + start_i&en_i -> RUN; RUN -> DRAIN when every replica's iteration count >= cfg_iter_num_i; DRAIN -> DONE when no read is outstanding; flush_i (any state, en_i high) -> IDLE next cycle, flush priority over start_i.
REQ-023 SHALL on RUN entry clear all per-replica iteration counters, set best_energy_o to most-positive signed value, best_spin_o to 0, and best_replica_o to 0.
REQ-024 SHALL grant only in RUN with en_i high: round-robin, at most one grant per cycle, combinational in the request cycle; search starts at pointer, pointer <- granted index+1 (wraps NUM_REPLICA-1 -> 0).
REQ-025 SHALL drive mem_ren_o = |rep_gnt_o and mem_raddr_o = address of granted replica, 0 when no grant.
REQ-026 SHALL assert rep_rvalid_o[k] exactly one cycle after rep_gnt_o[k]; flush suppresses a pending rvalid.
REQ-027 SHALL drive energy_ready_o[k] = en_i & RUN & (iter_cnt[k] < cfg_iter_num_i); the handshake is valid&ready.
REQ-028 SHALL increment iter_cnt[k] on each handshake of k, saturating at all-ones; simultaneous handshakes from several replicas all count in the same cycle.
REQ-029 SHALL select, among same-cycle handshakes, the signed-minimum energy (tie -> lowest index), and update best record only if strictly less than current best_energy_o; update visible next cycle.
REQ-030 SHALL with cfg_iter_num_i = 0 move RUN -> DRAIN on the cycle after entry with no energy accepted.
REQ-031 SHALL with en_i low hold state, counters, pointer and record; grants, ready and mem_ren_o are 0.

Reset
REQ-032 SHALL on rst_i asynchronously force IDLE, pointer 0, counters 0, no pending rvalid, best_energy_o most-positive, best_spin_o 0, best_replica_o 0, all handshake outputs 0, busy_o 0, done_o 0; reset mid-run discards the run.

Verification
REQ-033 SHALL cover: NUM_REPLICA=4, all rep_ren_i high continuously in RUN -> grants 0,1,2,3,0 on consecutive cycles, each rvalid one cycle later.
REQ-034 SHALL cover: replicas 1 and 3 deliver -5 and -5 same cycle -> best_energy_o=-5, best_replica_o=1 next cycle; later -5 from 2 -> no change.
REQ-035 SHALL cover: cfg_iter_num_i=2, each replica delivers 2 results -> energy_ready_o drops per replica after its 2nd, DRAIN then DONE, done_o=1.
REQ-036 SHALL cover: flush_i asserted one cycle after a grant -> IDLE next cycle, no rvalid emitted, busy_o=0.
REQ-037 SHALL cover: cfg_iter_num_i=0 -> RUN, DRAIN, DONE in three cycles with no grants accepted after RUN, best_energy_o=32'h7FFFFFFF.
REQ-038 SHALL cover: rst_i pulse mid-RUN and en_i low for 3 cycles mid-RUN -> reset values immediately; frozen state with zero grants/ready.
